i2s_sample_transmitter: RTL and testbench



---
 rtl/i2s_sample_transmitter.sv | 105 ++++++++++
 tb/tb_i2s_sample_transmitter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_sample_transmitter.sv
// i2s_sample_transmitter: one-entry buffered mono sample to Philips I2S serializer.
// Each latched word goes out on both slots; an empty buffer at latch repeats the last word.
module i2s_sample_transmitter #(
    parameter int CLK_DIV_HALF = 4,
    parameter int SLOT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [SLOT_WIDTH-1:0] sample,
    input  logic                  sample_valid,
    output logic                  sample_ready,
    input  logic                  mute,
    output logic                  i2s_bclk,
    output logic                  i2s_lrclk,
    output logic                  i2s_data,
    output logic                  underrun,
    output logic                  frame_start
);
    localparam int PW = $clog2(SLOT_WIDTH);
    localparam int CW = PW + 1;
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV_HALF - 1);
    localparam logic [CW-1:0] CNT_ONE = 1;

    logic [7:0]            r_div;
    logic                  r_bclk;
    logic [CW-1:0]         r_cnt;
    logic                  r_lrclk;
    logic                  r_data;
    logic                  r_underrun;
    logic                  r_frame_start;
    logic [SLOT_WIDTH-1:0] r_buf;
    logic                  r_full;
    logic [SLOT_WIDTH-1:0] r_last;
    logic [SLOT_WIDTH-1:0] r_word;

    logic                  w_wrap;
    logic                  w_fall;
    logic                  w_latch;
    logic                  w_accept;
    logic [CW-1:0]         w_cnt_nxt;
    logic [PW-1:0]         w_idx;
    logic [SLOT_WIDTH-1:0] w_src;
    logic [SLOT_WIDTH-1:0] w_tx;

    assign w_wrap    = (r_div == DIV_LAST);
    assign w_fall    = w_wrap && r_bclk;
    assign w_cnt_nxt = r_cnt + CNT_ONE;
    assign w_latch   = w_fall && (w_cnt_nxt == CNT_ONE);
    assign w_accept  = sample_valid && !r_full;
    assign w_src     = r_full ? r_buf : r_last;
    assign w_tx      = mute ? '0 : w_src;

    // One-bit I2S delay: slot position p carries bit (SLOT_WIDTH - p) mod SLOT_WIDTH
    assign w_idx = {PW{1'b0}} - w_cnt_nxt[PW-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div         <= '0;
            r_bclk        <= 1'b0;
            r_cnt         <= '0;
            r_lrclk       <= 1'b0;
            r_data        <= 1'b0;
            r_underrun    <= 1'b0;
            r_frame_start <= 1'b0;
            r_buf         <= '0;
            r_full        <= 1'b0;
            r_last        <= '0;
            r_word        <= '0;
        end else begin
            r_underrun    <= 1'b0;
            r_frame_start <= 1'b0;
            r_div         <= w_wrap ? 8'd0 : r_div + 8'd1;
            if (w_wrap) begin
                r_bclk <= !r_bclk;
            end
            if (w_fall) begin
                r_cnt   <= w_cnt_nxt;
                r_lrclk <= w_cnt_nxt[PW];
                r_data  <= r_word[w_idx];
            end
            // Left MSB: take the buffer (or repeat), muted words still consume it
            if (w_latch) begin
                r_word        <= w_tx;
                r_data        <= w_tx[SLOT_WIDTH-1];
                r_last        <= w_src;
                r_frame_start <= 1'b1;
                r_underrun    <= !r_full;
            end
            if (w_accept) begin
                r_buf  <= sample;
                r_full <= 1'b1;
            end else if (w_latch) begin
                r_full <= 1'b0;
            end
        end
    end

    assign sample_ready = !r_full;
    assign i2s_bclk     = r_bclk;
    assign i2s_lrclk    = r_lrclk;
    assign i2s_data     = r_data;
    assign underrun     = r_underrun;
    assign frame_start  = r_frame_start;

endmodule

// File: tb/tb_i2s_sample_transmitter.sv
// Bench for i2s_sample_transmitter: per-clk serial-stream reference model,
// directed frame table, streaming, mid-frame reset and randomized traffic.
module tb_i2s_sample_transmitter;
    localparam int CDH   = 4;
    localparam int BCLK  = 2 * CDH;
    localparam int NV    = 11;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] sample;
    logic        sample_valid;
    logic        sample_ready;
    logic        mute;
    logic        i2s_bclk;
    logic        i2s_lrclk;
    logic        i2s_data;
    logic        underrun;
    logic        frame_start;

    int n_vec = 0;
    int n_bad = 0;

    bit          m_on   = 1'b0;
    int          m_t    = 0;
    bit          m_full = 1'b0;
    logic [15:0] m_buf  = '0;
    logic [15:0] m_last = '0;
    bit          m_fs   = 1'b0;
    bit          m_ur   = 1'b0;
    logic [15:0] m_words[$];

    typedef struct {
        logic [15:0] smp;
        bit          give;
        bit          mute;
        logic [15:0] exp_word;
        bit          exp_ur;
    } vec_t;

    vec_t tv[NV];

    i2s_sample_transmitter #(
        .CLK_DIV_HALF(CDH),
        .SLOT_WIDTH  (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sample      (sample),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .mute        (mute),
        .i2s_bclk    (i2s_bclk),
        .i2s_lrclk   (i2s_lrclk),
        .i2s_data    (i2s_data),
        .underrun    (underrun),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0d)", nm, act, exp, m_t);
        end
    endtask

    // Serial stream view: after n falling edges the line carries stream bit n-1,
    // where the stream is each frame word sent MSB-first twice (left, right).
    function automatic logic [5:0] exp_out();
        int          n;
        int          m;
        logic [15:0] w;
        logic        b;
        n = m_t / BCLK;
        b = 1'b0;
        if (n > 0) begin
            m = n - 1;
            w = m_words[m / 32];
            b = w[15 - (m % 16)];
        end
        return {1'((m_t / CDH) % 2), ((n % 32) >= 16), b, !m_full, m_ur, m_fs};
    endfunction

    task automatic model_loop();
        bit          pre;
        int          n;
        logic [15:0] w;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_on   = 1'b1;
                m_t    = 0;
                m_full = 1'b0;
                m_buf  = '0;
                m_last = '0;
                m_fs   = 1'b0;
                m_ur   = 1'b0;
                m_words.delete();
            end else if (m_on) begin
                m_t++;
                m_fs = 1'b0;
                m_ur = 1'b0;
                pre  = m_full;
                n    = m_t / BCLK;
                if ((m_t % BCLK) == 0 && (n % 32) == 1) begin
                    m_fs = 1'b1;
                    if (pre) begin
                        w      = m_buf;
                        m_last = m_buf;
                        m_full = 1'b0;
                    end else begin
                        w    = m_last;
                        m_ur = 1'b1;
                    end
                    m_words.push_back(mute ? 16'h0000 : w);
                end
                if (sample_valid && !pre) begin
                    m_buf  = sample;
                    m_full = 1'b1;
                end
            end
        end
    endtask

    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            if (m_on) begin
                chk("cycle_outputs",
                    {26'd0, i2s_bclk, i2s_lrclk, i2s_data, sample_ready,
                     underrun, frame_start},
                    {26'd0, exp_out()});
            end
        end
    endtask

    task automatic wait_fs(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (frame_start) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_bad++;
            $display("FAIL fs_timeout: got no frame_start, expected one within 400 clk");
        end
    endtask

    task automatic give(input logic [15:0] v);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (sample_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            n_vec++;
            n_bad++;
            $display("FAIL ready_timeout: got ready=0, expected 1 within 400 clk");
        end
        sample_valid = 1'b1;
        sample       = v;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic capture(output logic [15:0] l, output logic [15:0] r,
                           output logic ur);
        bit ok;
        wait_fs(ok);
        ur    = underrun;
        l[15] = i2s_data;
        for (int i = 14; i >= 0; i--) begin
            repeat (BCLK) @(negedge clk);
            l[i] = i2s_data;
        end
        for (int i = 15; i >= 0; i--) begin
            repeat (BCLK) @(negedge clk);
            r[i] = i2s_data;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [15:0] l;
        logic [15:0] r;
        logic        ur;
        bit          ok;
        bit          gap;
        int          cnt;
        int          t_bclk;
        int          t_fs;

        tv[0]  = '{16'h8001, 1'b1, 1'b0, 16'h8001, 1'b0};
        tv[1]  = '{16'h1234, 1'b1, 1'b0, 16'h1234, 1'b0};
        tv[2]  = '{16'h0000, 1'b0, 1'b0, 16'h1234, 1'b1};
        tv[3]  = '{16'h0000, 1'b0, 1'b0, 16'h1234, 1'b1};
        tv[4]  = '{16'h0000, 1'b0, 1'b0, 16'h1234, 1'b1};
        tv[5]  = '{16'h7FFF, 1'b1, 1'b1, 16'h0000, 1'b0};
        tv[6]  = '{16'h0000, 1'b0, 1'b0, 16'h7FFF, 1'b1};
        tv[7]  = '{16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b0};
        tv[8]  = '{16'hA5C3, 1'b1, 1'b0, 16'hA5C3, 1'b0};
        tv[9]  = '{16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1};
        tv[10] = '{16'h0000, 1'b0, 1'b0, 16'hA5C3, 1'b1};

        reset        = 1'b1;
        sample_valid = 1'b0;
        sample       = '0;
        mute         = 1'b0;
        fork
            model_loop();
            monitor_loop();
        join_none

        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {27'd0, i2s_bclk, i2s_lrclk, i2s_data, underrun, frame_start}, 32'd0);
        chk("reset_ready", {31'd0, sample_ready}, 32'd1);
        reset = 1'b0;

        for (int k = 0; k < NV; k++) begin
            mute = tv[k].mute;
            if (tv[k].give) give(tv[k].smp);
            capture(l, r, ur);
            chk($sformatf("frame%0d_left", k), {16'd0, l}, {16'd0, tv[k].exp_word});
            chk($sformatf("frame%0d_right", k), {16'd0, r}, {16'd0, tv[k].exp_word});
            chk($sformatf("frame%0d_underrun", k), {31'd0, ur}, {31'd0, tv[k].exp_ur});
        end

        do_reset();
        sample       = 16'h0001;
        sample_valid = 1'b1;
        @(negedge clk);
        sample = 16'h0002;
        for (int k = 1; k <= 4; k++) begin
            capture(l, r, ur);
            chk($sformatf("stream%0d_left", k), {16'd0, l}, k);
            chk($sformatf("stream%0d_right", k), {16'd0, r}, k);
            chk($sformatf("stream%0d_underrun", k), {31'd0, ur}, 32'd0);
            sample = 16'(k + 2);
        end
        sample_valid = 1'b0;

        wait_fs(ok);
        repeat (8 * BCLK) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_lines", {29'd0, i2s_bclk, i2s_lrclk, i2s_data}, 32'd0);
        chk("midreset_ready", {31'd0, sample_ready}, 32'd1);
        reset  = 1'b0;
        t_bclk = 0;
        t_fs   = 0;
        cnt    = 0;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (t_bclk == 0 && i2s_bclk) t_bclk = i;
            if (t_fs == 0 && frame_start) t_fs = i;
            if (i2s_lrclk) begin
                cnt = i;
                break;
            end
        end
        chk("restart_bclk_rise", t_bclk, CDH);
        chk("restart_first_latch", t_fs, BCLK);
        chk("restart_lrclk_rise", cnt, 16 * BCLK);

        for (int f = 0; f < 8; f++) begin
            gap = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < 32 * BCLK; i++) begin
                sample_valid = !gap && ($urandom_range(0, 63) == 0);
                sample       = 16'($urandom);
                mute         = ($urandom_range(0, 3) == 0);
                @(negedge clk);
            end
        end
        sample_valid = 1'b0;
        mute         = 1'b0;
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
